// File: rtl/aig_tt_sweeper.sv
// Exhaustive truth-table sweeper for a combinational AIG netlist: walks every
// input vector, samples z after a settle window and compares with a golden table.
module aig_tt_sweeper #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [(1<<N_INPUTS)-1:0]  expected_tt,
  output logic [N_INPUTS-1:0]       dut_x,
  input  logic                      dut_z,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [(1<<N_INPUTS)-1:0]  captured_tt,
  output logic [N_INPUTS:0]         mismatch_count,
  output logic [N_INPUTS-1:0]       mismatch_idx
);

  localparam int TT_W = 1 << N_INPUTS;
  localparam int CW   = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SC_MAX = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   settle_cnt;
  logic [TT_W-1:0] exp_tt;
  logic            first_seen;
  logic            sample;
  logic            last_vec;
  logic            mm;

  assign sample   = (state == S_RUN) && (settle_cnt == SC_MAX);
  assign last_vec = (dut_x == '1);
  assign mm       = (dut_z != exp_tt[dut_x]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // busy/done are pure state decodes, which lines them up with the RUN/DONE cycles
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (sample && last_vec) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_x          <= '0;
      settle_cnt     <= '0;
      exp_tt         <= '0;
      captured_tt    <= '0;
      mismatch_count <= '0;
      mismatch_idx   <= '0;
      first_seen     <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            exp_tt         <= expected_tt;
            captured_tt    <= '0;
            mismatch_count <= '0;
            mismatch_idx   <= '0;
            first_seen     <= 1'b0;
            pass           <= 1'b0;
            dut_x          <= '0;
            settle_cnt     <= '0;
          end
        end
        S_RUN: begin
          if (!sample) begin
            settle_cnt <= settle_cnt + 1'b1;
          end else begin
            captured_tt[dut_x] <= dut_z;
            if (mm) begin
              mismatch_count <= mismatch_count + 1'b1;
              if (!first_seen) begin
                mismatch_idx <= dut_x;
                first_seen   <= 1'b1;
              end
            end
            if (!last_vec) begin
              dut_x      <= dut_x + 1'b1;
              settle_cnt <= '0;
            end else begin
              // final vector's own mismatch counts towards the verdict
              pass <= (mismatch_count == '0) && !mm;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aig_tt_sweeper.sv
// Scoreboard bench for aig_tt_sweeper with netlist model z = x1 | ~x2 | ~x3.
module tb_aig_tt_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] expected_tt;
  logic       zmode;

  logic [2:0] x1, x0, x3;
  logic       z1, z0, z3;
  logic       busy1, busy0, busy3;
  logic       done1, done0, done3;
  logic       pass1, pass0, pass3;
  logic [7:0] tt1, tt0, tt3;
  logic [3:0] cnt1, cnt0, cnt3;
  logic [2:0] idx1, idx0, idx3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] tt;
    logic       pass;
    logic [3:0] cnt;
    logic [2:0] idx;
  } res_t;
  res_t sb[$];

  always #5 clk = ~clk;

  function automatic logic model_z(input logic [2:0] x);
    return x[2] | ~x[1] | ~x[0];
  endfunction

  assign z1 = zmode ? 1'b0 : model_z(x1);
  assign z0 = zmode ? 1'b0 : model_z(x0);
  assign z3 = zmode ? 1'b0 : model_z(x3);

  aig_tt_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .expected_tt(expected_tt),
    .dut_x(x1), .dut_z(z1), .busy(busy1), .done(done1), .pass(pass1),
    .captured_tt(tt1), .mismatch_count(cnt1), .mismatch_idx(idx1));

  aig_tt_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .start(start), .expected_tt(expected_tt),
    .dut_x(x0), .dut_z(z0), .busy(busy0), .done(done0), .pass(pass0),
    .captured_tt(tt0), .mismatch_count(cnt0), .mismatch_idx(idx0));

  aig_tt_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .start(start), .expected_tt(expected_tt),
    .dut_x(x3), .dut_z(z3), .busy(busy3), .done(done3), .pass(pass3),
    .captured_tt(tt3), .mismatch_count(cnt3), .mismatch_idx(idx3));

  function automatic res_t predict(input logic [7:0] exp, input logic zm);
    res_t r;
    logic z;
    logic first;
    r.tt = '0; r.cnt = '0; r.idx = '0; first = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      z = zm ? 1'b0 : model_z(3'(i));
      r.tt[i] = z;
      if (z != exp[i]) begin
        r.cnt = r.cnt + 1'b1;
        if (!first) begin r.idx = 3'(i); first = 1'b1; end
      end
    end
    r.pass = (r.cnt == 0);
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((busy1 || busy0 || busy3 || done1 || done0 || done3) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (busy1 || busy0 || busy3) begin
      errors++;
      $display("FAIL wait_idle: busy still high after %0d cycles (required 0)", n);
    end
  endtask

  // one sweep on the main instance; inject_at >= 0 pulses start and zeroes expected_tt mid-RUN
  task automatic run_sweep(input string name, input logic [7:0] exp, input int inject_at);
    res_t e;
    int cycles = 0;
    bit seen = 0;
    @(negedge clk);
    expected_tt = exp;
    start = 1'b1;
    sb.push_back(predict(exp, zmode));
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen && cycles < 200) begin
      if (cycles == inject_at) begin start = 1'b1; expected_tt = 8'h00; end
      else start = 1'b0;
      @(posedge clk); #1;
      cycles++;
      if (done1) seen = 1;
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: no done after %0d cycles (required 16)", name, cycles);
      return;
    end
    if (cycles != 16) begin
      errors++;
      $display("FAIL %s run_cycles: got %0d required 16", name, cycles);
    end
    checks++;
    if (tt1 !== e.tt) begin errors++; $display("FAIL %s captured_tt: got %h required %h", name, tt1, e.tt); end
    checks++;
    if (pass1 !== e.pass) begin errors++; $display("FAIL %s pass: got %b required %b", name, pass1, e.pass); end
    checks++;
    if (cnt1 !== e.cnt) begin errors++; $display("FAIL %s mismatch_count: got %0d required %0d", name, cnt1, e.cnt); end
    checks++;
    if (idx1 !== e.idx) begin errors++; $display("FAIL %s mismatch_idx: got %0d required %0d", name, idx1, e.idx); end
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b required 0", name, busy1); end
    @(posedge clk); #1;
    checks++;
    if (done1 !== 1'b0) begin errors++; $display("FAIL %s done_pulse_width: got %b required 0", name, done1); end
    checks++;
    if (tt1 !== e.tt || pass1 !== e.pass || x1 !== 3'd7) begin
      errors++;
      $display("FAIL %s hold_in_idle: tt=%h pass=%b x=%0d required tt=%h pass=%b x=7", name, tt1, pass1, x1, e.tt, e.pass);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({x1, busy1, done1, pass1, tt1, cnt1, idx1} !== '0) begin
      errors++;
      $display("FAIL %s: x=%0d busy=%b done=%b pass=%b tt=%h cnt=%0d idx=%0d required all 0",
               name, x1, busy1, done1, pass1, tt1, cnt1, idx1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; expected_tt = 8'hF7; zmode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_zero("idle_after_reset");
  endtask

  task automatic test_match();
    zmode = 1'b0;
    run_sweep("match_f7", 8'hF7, -1);
  endtask

  task automatic test_mismatch();
    zmode = 1'b0;
    run_sweep("single_mismatch_ff", 8'hFF, -1);
    zmode = 1'b1;
    run_sweep("z_zero_a5", 8'hA5, -1);
    zmode = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_sweep("back_to_back_a", 8'hF7, -1);
    run_sweep("back_to_back_b", 8'h0F, -1);
  endtask

  task automatic test_ignore_midrun();
    run_sweep("midrun_ignore", 8'hF7, 5);
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    bit saw_done = 0;
    wait_idle();
    @(negedge clk);
    expected_tt = 8'hF7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (x1 !== 3'd5 && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (x1 !== 3'd5) begin errors++; $display("FAIL rst_midrun_reach_x5: x=%0d required 5", x1); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("rst_midrun_outputs");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL rst_midrun_no_done: got done=1 required 0"); end
    run_sweep("after_rst_sweep", 8'hF7, -1);
  endtask

  task automatic test_settle_variants();
    int n = 0;
    int c0 = -1, c3 = -1;
    logic [7:0] t0 = '0, t3 = '0;
    zmode = 1'b0;
    wait_idle();
    @(negedge clk);
    expected_tt = 8'hF7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while ((c0 < 0 || c3 < 0) && n < 100) begin
      @(posedge clk); #1; n++;
      if (done0 && c0 < 0) begin c0 = n; t0 = tt0; end
      if (done3 && c3 < 0) begin c3 = n; t3 = tt3; end
    end
    checks++;
    if (c0 != 8) begin errors++; $display("FAIL settle0_cycles: got %0d required 8", c0); end
    checks++;
    if (c3 != 32) begin errors++; $display("FAIL settle3_cycles: got %0d required 32", c3); end
    checks++;
    if (t0 !== 8'hF7) begin errors++; $display("FAIL settle0_captured_tt: got %h required f7", t0); end
    checks++;
    if (t3 !== 8'hF7) begin errors++; $display("FAIL settle3_captured_tt: got %h required f7", t3); end
    checks++;
    if (pass0 !== 1'b1 || pass3 !== 1'b1) begin
      errors++;
      $display("FAIL settle_pass: got %b/%b required 1/1", pass0, pass3);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_back_to_back();
    test_ignore_midrun();
    test_reset_midrun();
    test_settle_variants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
